// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues 1-cycle-latency imem reads and buffers {word, pc} for decode.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_unit #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_pc,
  output logic          o_pc_incr,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic [IW-1:0] i_imem_rdata,
  input  logic          i_flush,
  output logic          o_inst_valid,
  input  logic          i_inst_ready,
  output logic [IW-1:0] o_inst_out,
  output logic [AW-1:0] o_inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   o_perf_fetch_cnt,
  output logic [31:0]   o_perf_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = IW + AW;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t        r_state;
  logic          r_inflight;
  logic [AW-1:0] r_req_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_head;
  logic [EW-1:0] r_mem [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_room;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_push_data;
  logic [PW-1:0] w_rd_next;
  logic [CW-1:0] w_cnt_after_pop;
  logic [CW-1:0] w_cnt_next;
  logic          w_head_is_push;

  // A slot stays reserved for the read in flight, so the FIFO can never overflow.
  assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_room = w_occ < DEPTH_V;
  assign w_req  = !reset && (r_state == S_RUN) && w_room && !i_flush;

  assign o_imem_req  = w_req;
  assign o_pc_incr   = w_req;
  assign o_imem_addr = i_pc;

  assign w_push          = r_inflight && !i_flush;
  assign w_pop           = o_inst_valid && i_inst_ready;
  assign w_push_data     = {i_imem_rdata, r_req_pc};
  assign w_rd_next       = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - CW'(w_pop);
  assign w_cnt_next      = w_cnt_after_pop + CW'(w_push);
  assign w_head_is_push  = w_push && (w_cnt_after_pop == '0);

  assign o_inst_valid = (r_count != '0);
  assign o_inst_out   = r_head[EW-1:AW];
  assign o_inst_pc    = r_head[AW-1:0];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // The head register is refreshed only while the FIFO holds data, so an empty FIFO keeps the last word visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_req_pc <= i_pc;
      if (i_flush) begin
        r_state  <= S_FLUSH;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_state  <= S_RUN;
        r_count  <= w_cnt_next;
        r_rd_ptr <= w_rd_next;
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_cnt_next != '0)
          r_head <= w_head_is_push ? w_push_data : r_mem[w_rd_next];
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_perf_fetch_cnt <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (w_push) o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
      if (r_state == S_RUN && !i_flush && !w_room)
        o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC model and a 1-cycle instruction memory model.
// Perf counter checks are compiled in when IFETCH_PERF_EN is defined.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pcReg;
  logic        pcIncr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        flush;
  logic        instValid;
  logic        instReady;
  logic [31:0] instOut;
  logic [31:0] instPc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perfFetchCnt;
  logic [31:0] perfStallCnt;
`endif

  int          errors = 0;
  int          checks = 0;
  int          reqCount;
  logic [31:0] flushTarget;
  logic [31:0] gotPc[$];
  logic [31:0] gotInst[$];

  ifetch_unit #(.AW(32), .IW(32), .DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_pc         (pcReg),
    .o_pc_incr    (pcIncr),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_rdata (imemRdata),
    .i_flush      (flush),
    .o_inst_valid (instValid),
    .i_inst_ready (instReady),
    .o_inst_out   (instOut),
    .o_inst_pc    (instPc)
`ifdef IFETCH_PERF_EN
    ,
    .o_perf_fetch_cnt (perfFetchCnt),
    .o_perf_stall_cnt (perfStallCnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // One clock: record pops/requests before the edge, then update the PC and memory models after it.
  task automatic tick();
    logic        incr, req, fl;
    logic [31:0] addr;
    #1;
    incr = pcIncr;
    req  = imemReq;
    fl   = flush;
    addr = imemAddr;
    if (instValid && instReady) begin
      gotPc.push_back(instPc);
      gotInst.push_back(instOut);
    end
    if (req) reqCount++;
    @(posedge clock);
    #1;
    if (fl) pcReg = flushTarget;
    else if (incr) pcReg = pcReg + 32'd1;
    imemRdata = req ? word(addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic applyReset(input logic rdy);
    reset     = 1'b1;
    flush     = 1'b0;
    instReady = rdy;
    pcReg     = '0;
    imemRdata = '0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    gotPc.delete();
    gotInst.delete();
    reqCount = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #2;
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instValid); end
    checks++; if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imemReq); end
    checks++; if (pcIncr !== 1'b0) begin errors++; $display("[TB] FAIL reset_incr got %b exp 0", pcIncr); end
    checks++; if (instOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_out got %h exp 0", instOut); end
    checks++; if (instPc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0", instPc); end
  endtask

  task automatic test_fill();
    applyReset(1'b1);
    #1;
    checks++; if (pcIncr !== 1'b1 || imemAddr !== 32'd0) begin errors++; $display("[TB] FAIL fill_first_req got incr=%b addr=%h exp 1/0", pcIncr, imemAddr); end
    tick();
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL fill_valid_early got %b exp 0", instValid); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd0 || instOut !== word(0)) begin errors++; $display("[TB] FAIL fill_first got v=%b pc=%h out=%h exp 1/0/%h", instValid, instPc, instOut, word(0)); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd1 || instOut !== word(1)) begin errors++; $display("[TB] FAIL fill_second got v=%b pc=%h out=%h exp 1/1/%h", instValid, instPc, instOut, word(1)); end
    tick();
    checks++; if (instValid !== 1'b0 || instPc !== 32'd1 || instOut !== word(1)) begin errors++; $display("[TB] FAIL fill_empty_hold got v=%b pc=%h out=%h exp 0/1/%h", instValid, instPc, instOut, word(1)); end
    repeat (2) tick();
    checks++; if (gotPc.size() !== 3) begin errors++; $display("[TB] FAIL fill_count got %0d exp 3", gotPc.size()); end
    for (int i = 0; i < gotPc.size(); i++) begin
      checks++; if (gotPc[i] !== 32'(i) || gotInst[i] !== word(32'(i))) begin errors++; $display("[TB] FAIL fill_seq[%0d] got pc=%h inst=%h exp %h/%h", i, gotPc[i], gotInst[i], i, word(32'(i))); end
    end
  endtask

  task automatic test_stall();
    applyReset(1'b0);
    repeat (5) tick();
    checks++; if (reqCount !== 2) begin errors++; $display("[TB] FAIL stall_reqs got %0d exp 2", reqCount); end
    checks++; if (pcReg !== 32'd2 || pcIncr !== 1'b0 || imemReq !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold got pc=%h incr=%b req=%b exp 2/0/0", pcReg, pcIncr, imemReq); end
    checks++; if (instValid !== 1'b1 || instPc !== 32'd0 || instOut !== word(0)) begin errors++; $display("[TB] FAIL stall_head got v=%b pc=%h out=%h exp 1/0/%h", instValid, instPc, instOut, word(0)); end
    instReady = 1'b1;
    tick();
    checks++; if (instPc !== 32'd1 || instOut !== word(1) || imemReq !== 1'b1 || imemAddr !== 32'd2) begin errors++; $display("[TB] FAIL stall_resume got pc=%h out=%h req=%b addr=%h exp 1/%h/1/2", instPc, instOut, imemReq, imemAddr, word(1)); end
    tick();
    checks++; if (instValid !== 1'b0 || instPc !== 32'd1) begin errors++; $display("[TB] FAIL stall_drained got v=%b pc=%h exp 0/1", instValid, instPc); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd2 || instOut !== word(2)) begin errors++; $display("[TB] FAIL stall_next got v=%b pc=%h out=%h exp 1/2/%h", instValid, instPc, instOut, word(2)); end
    checks++; if (gotPc.size() !== 2 || gotPc[0] !== 32'd0 || gotPc[1] !== 32'd1) begin errors++; $display("[TB] FAIL stall_pops got n=%0d exp pcs 0,1", gotPc.size()); end
  endtask

  task automatic test_flush();
    applyReset(1'b1);
    repeat (6) tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd3 || imemReq !== 1'b1 || imemAddr !== 32'd4) begin errors++; $display("[TB] FAIL flush_setup got v=%b pc=%h req=%b addr=%h exp 1/3/1/4", instValid, instPc, imemReq, imemAddr); end
    instReady = 1'b0;
    tick();
    checks++; if (pcReg !== 32'd5 || instPc !== 32'd3 || imemReq !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre got pc=%h head=%h req=%b exp 5/3/0", pcReg, instPc, imemReq); end
    flush = 1'b1;
    flushTarget = 32'd20;
    #1;
    checks++; if (imemReq !== 1'b0 || pcIncr !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle got req=%b incr=%b exp 0/0", imemReq, pcIncr); end
    tick();
    flush = 1'b0;
    instReady = 1'b1;
    gotPc.delete();
    gotInst.delete();
    #1;
    checks++; if (instValid !== 1'b0 || imemReq !== 1'b0 || pcReg !== 32'd20) begin errors++; $display("[TB] FAIL flush_state got v=%b req=%b pc=%h exp 0/0/20", instValid, imemReq, pcReg); end
    tick();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'd20) begin errors++; $display("[TB] FAIL flush_refetch got req=%b addr=%h exp 1/20", imemReq, imemAddr); end
    repeat (4) tick();
    checks++;
    if (gotPc.size() == 0) begin errors++; $display("[TB] FAIL flush_target got no delivery exp pc 20"); end
    else if (gotPc[0] !== 32'd20 || gotInst[0] !== word(20)) begin errors++; $display("[TB] FAIL flush_target got pc=%h inst=%h exp 20/%h", gotPc[0], gotInst[0], word(20)); end
  endtask

  task automatic test_back_to_back();
    applyReset(1'b0);
    repeat (2) tick();
    instReady = 1'b1;
    #1;
    checks++; if (imemReq !== 1'b0 || instPc !== 32'd0) begin errors++; $display("[TB] FAIL b2b_setup got req=%b pc=%h exp 0/0", imemReq, instPc); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd1 || instOut !== word(1)) begin errors++; $display("[TB] FAIL b2b_pushpop got v=%b pc=%h out=%h exp 1/1/%h", instValid, instPc, instOut, word(1)); end
    repeat (6) tick();
    checks++; if (gotPc.size() !== 5) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 5", gotPc.size()); end
    for (int i = 0; i < gotPc.size(); i++) begin
      checks++; if (gotPc[i] !== 32'(i) || gotInst[i] !== word(32'(i))) begin errors++; $display("[TB] FAIL b2b_order[%0d] got pc=%h inst=%h exp %h/%h", i, gotPc[i], gotInst[i], i, word(32'(i))); end
    end
  endtask

  task automatic test_async_reset();
    applyReset(1'b0);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    pcReg = '0;
    #1;
    checks++; if (instValid !== 1'b0 || instOut !== 32'h0 || instPc !== 32'h0 || imemReq !== 1'b0 || pcIncr !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got v=%b out=%h pc=%h req=%b incr=%b exp all 0", instValid, instOut, instPc, imemReq, pcIncr); end
    @(posedge clock);
    #3;
    reset = 1'b0;
    instReady = 1'b1;
    gotPc.delete();
    gotInst.delete();
    #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin errors++; $display("[TB] FAIL async_restart got req=%b addr=%h exp 1/0", imemReq, imemAddr); end
    repeat (2) tick();
    checks++; if (instValid !== 1'b1 || instPc !== 32'd0 || instOut !== word(0)) begin errors++; $display("[TB] FAIL async_first got v=%b pc=%h out=%h exp 1/0/%h", instValid, instPc, instOut, word(0)); end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    applyReset(1'b0);
    checks++; if (perfFetchCnt !== 32'd0 || perfStallCnt !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset got %0d/%0d exp 0/0", perfFetchCnt, perfStallCnt); end
    repeat (12) tick();
    checks++; if (perfFetchCnt !== 32'd2) begin errors++; $display("[TB] FAIL perf_fetch got %0d exp 2", perfFetchCnt); end
    checks++; if (perfStallCnt !== 32'd10) begin errors++; $display("[TB] FAIL perf_stall got %0d exp 10", perfStallCnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    pcReg       = '0;
    flush       = 1'b0;
    instReady   = 1'b0;
    imemRdata   = '0;
    flushTarget = '0;
    reqCount    = 0;
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
